// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, drives the synchronous instruction
// memory and hands returned words to decode through a small FIFO.
module fetch_sequencer #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              if_ready,
    output logic              running
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              resp_pending_q, resp_pending_d;
    logic              squash_q, squash_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [DATA_W-1:0] instr_d [DEPTH];
    logic [ADDR_W-1:0] pcbuf_q [DEPTH];
    logic [ADDR_W-1:0] pcbuf_d [DEPTH];

    logic              pop;
    logic              push;
    logic              issue;
    int                occ;
    int                wr_idx;

    // Handshake, issue and push qualifiers.
    always_comb begin
        pop    = (count_q != '0) && if_ready;
        occ    = int'(count_q) + int'(resp_pending_q) - int'(pop);
        issue  = (state_q == S_RUN) && !halt && !redirect_valid
                 && (occ < DEPTH);
        push   = resp_pending_q && !squash_q && !redirect_valid;
        wr_idx = int'(count_q) - int'(pop);
    end

    // Run-state transitions; halt wins over start while running.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_RUN;
            S_RUN:    if (halt) state_d = S_HALTED;
            S_HALTED: if (start && !halt) state_d = S_RUN;
            default:  state_d = S_IDLE;
        endcase
    end

    // Fetch PC, outstanding-response tracking and redirect squash.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        pend_pc_d      = pend_pc_q;
        resp_pending_d = issue;
        squash_d       = 1'b0;
        if (issue) begin
            pend_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 1'b1;
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            squash_d   = resp_pending_q;
        end
    end

    // Shift-register FIFO; head stays put when the last entry pops.
    always_comb begin
        instr_d = instr_q;
        pcbuf_d = pcbuf_q;
        count_d = count_q;
        if (redirect_valid) begin
            count_d = '0;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (pop && (i + 1 < int'(count_q))) begin
                    instr_d[i] = instr_q[i+1];
                    pcbuf_d[i] = pcbuf_q[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (i == wr_idx)) begin
                    instr_d[i] = imem_rdata;
                    pcbuf_d[i] = pend_pc_q;
                end
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            fetch_pc_q     <= ADDR_W'(RESET_PC);
            pend_pc_q      <= '0;
            resp_pending_q <= 1'b0;
            squash_q       <= 1'b0;
            count_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pcbuf_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            pend_pc_q      <= pend_pc_d;
            resp_pending_q <= resp_pending_d;
            squash_q       <= squash_d;
            count_q        <= count_d;
            instr_q        <= instr_d;
            pcbuf_q        <= pcbuf_d;
        end
    end

    assign imem_addr = fetch_pc_q;
    assign if_valid  = (count_q != '0);
    assign if_instr  = instr_q[0];
    assign if_pc     = pcbuf_q[0];
    assign running   = (state_q == S_RUN);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, async reset sequence
// and randomized traffic against an instruction-stream reference model.
module tb_fetch_sequencer;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          halt;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          if_ready;
    logic          running;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(2), .RESET_PC(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .running(running)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {6'h2A, a, 6'h15, a};
    endfunction

    // Synchronous memory: data for the address seen at the edge.
    always @(posedge clk) imem_rdata <= word(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          st;
        logic          hl;
        logic          rv;
        logic [AW-1:0] rpc;
        logic          rdy;
        logic          ev;
        logic [AW-1:0] epc;
        logic          er;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic st, input logic hl, input logic rv,
                       input int rpc, input logic rdy, input logic ev,
                       input int epc, input logic er);
        vec_t v;
        v.st = st; v.hl = hl; v.rv = rv; v.rpc = AW'(rpc);
        v.rdy = rdy; v.ev = ev; v.epc = AW'(epc); v.er = er;
        tv.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        logic          pop;
        logic [AW-1:0] exp_pc;
        int            m_state;
        int            quiet;

        // start-up, stall, redirect, wrap, halt/resume
        add(1,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,1);
        add(0,0,0,0,1, 0,0,1);
        add(0,0,0,0,1, 1,0,1);
        add(0,0,0,0,1, 1,1,1);
        add(0,0,0,0,1, 1,2,1);
        for (int i = 0; i < 5; i++) add(0,0,0,0,0, 1,3,1);
        add(0,0,0,0,1, 1,3,1);
        add(0,0,0,0,1, 1,4,1);
        add(0,0,0,0,1, 1,5,1);
        add(0,0,1,'h200,0, 1,6,1);
        add(0,0,0,0,1, 0,0,1);
        add(0,0,0,0,1, 0,0,1);
        add(0,0,0,0,1, 1,'h200,1);
        add(0,0,0,0,1, 1,'h201,1);
        add(0,0,1,1022,1, 1,'h202,1);
        add(0,0,0,0,1, 0,0,1);
        add(0,0,0,0,1, 0,0,1);
        add(0,0,0,0,1, 1,1022,1);
        add(0,0,0,0,1, 1,1023,1);
        add(0,0,0,0,1, 1,0,1);
        add(0,0,0,0,1, 1,1,1);
        add(0,1,0,0,1, 1,2,1);
        add(0,1,0,0,1, 1,3,0);
        add(0,1,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(1,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,1);
        add(0,0,0,0,1, 0,0,1);
        add(0,0,0,0,1, 1,4,1);
        add(0,0,0,0,1, 1,5,1);

        reset = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", 32'(if_pc), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            start = tv[i].st;
            halt = tv[i].hl;
            redirect_valid = tv[i].rv;
            redirect_pc = tv[i].rpc;
            if_ready = tv[i].rdy;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(tv[i].ev));
            chk($sformatf("v%0d_running", i), 32'(running), 32'(tv[i].er));
            if (tv[i].ev) begin
                chk($sformatf("v%0d_pc", i), 32'(if_pc), 32'(tv[i].epc));
                chk($sformatf("v%0d_instr", i), if_instr, word(tv[i].epc));
            end
        end

        // async reset between edges while streaming
        @(negedge clk);
        start = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        chk("arst_pc", 32'(if_pc), 32'd0);
        chk("arst_instr", if_instr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (if_valid) begin
                lat = i;
                break;
            end
        end
        chk("arst_latency", 32'(lat), 32'd3);
        chk("arst_first_pc", 32'(if_pc), 32'd0);
        chk("arst_first_instr", if_instr, word(10'd0));

        // randomized traffic vs. instruction-stream model
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        if_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_pc = '0;
        m_state = 0;
        quiet = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            start = ($urandom_range(0, 7) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = AW'($urandom);
            if_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_running", 32'(running), 32'(m_state == 1));
            pop = if_valid && if_ready;
            if (redirect_valid) begin
                exp_pc = redirect_pc;
            end else if (pop) begin
                chk("rnd_pc", 32'(if_pc), 32'(exp_pc));
                chk("rnd_instr", if_instr, word(exp_pc));
                exp_pc = exp_pc + 1'b1;
            end
            if (m_state == 1 && !halt && !redirect_valid && if_ready)
                quiet++;
            else
                quiet = 0;
            if (quiet >= 3) chk("rnd_throughput", 32'(pop), 32'd1);
            case (m_state)
                0: if (start) m_state = 1;
                1: if (halt) m_state = 2;
                default: if (start && !halt) m_state = 1;
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
